// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data memory between two requesters. The memory has one read
// port and one write port, and its read data is registered (valid one cycle
// after the address). At most one access is accepted per cycle.
//   Port 0 : core MEM stage. It has priority.
//   Port 1 : debug/DMA master. A bounded starvation counter guarantees that
//            it makes progress.
//
// Optional build macro: DMEM_ARB_RR_EN
//   defined   -> pure round-robin between the two ports. starve_cnt and
//                STARVE_LIMIT are unused.
//   undefined -> port-0 priority with a starvation-forced grant for port 1.
//
// Ports:
//   clock, reset            : rising-edge clock; asynchronous active-high reset
//   in_reqN_valid/write     : request strobe, 1 = write / 0 = read
//   in_reqN_addr/wdata      : request address and write data
//   out_reqN_ready          : request accepted this cycle (combinational)
//   out_rspN_valid/rdata    : read response, one cycle after acceptance
//   out_mem_rd_addr         : read address to the memory
//   out_mem_wr_addr         : write address to the memory
//   out_mem_wr_word         : write data to the memory
//   out_mem_write_en        : write strobe to the memory
//   in_mem_rd_word          : memory read data (registered inside the memory)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int WORD_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_req0_valid,
    input  logic                  in_req0_write,
    input  logic [ADDR_WIDTH-1:0] in_req0_addr,
    input  logic [WORD_WIDTH-1:0] in_req0_wdata,
    output logic                  out_req0_ready,
    output logic                  out_rsp0_valid,
    output logic [WORD_WIDTH-1:0] out_rsp0_rdata,
    input  logic                  in_req1_valid,
    input  logic                  in_req1_write,
    input  logic [ADDR_WIDTH-1:0] in_req1_addr,
    input  logic [WORD_WIDTH-1:0] in_req1_wdata,
    output logic                  out_req1_ready,
    output logic                  out_rsp1_valid,
    output logic [WORD_WIDTH-1:0] out_rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] out_mem_rd_addr,
    output logic [ADDR_WIDTH-1:0] out_mem_wr_addr,
    output logic [WORD_WIDTH-1:0] out_mem_wr_word,
    output logic                  out_mem_write_en,
    input  logic [WORD_WIDTH-1:0] in_mem_rd_word
);

    // Grant decision for the current cycle. Grants are forced low while
    // reset is asserted, so ready and write_en read as 0 during reset.
    logic                  grant0_s;
    logic                  grant1_s;
    logic                  any_grant_s;
    logic                  sel_write_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [WORD_WIDTH-1:0] sel_wdata_s;

    // Copies of the last granted address and data. They drive the memory
    // side in cycles with no grant.
    logic [ADDR_WIDTH-1:0] hold_addr_r;
    logic [WORD_WIDTH-1:0] hold_wdata_r;

    // Read-owner pipeline: bit 0 = port 0, bit 1 = port 1, 2'b00 = none.
    logic [1:0]            pending_r;
    logic [WORD_WIDTH-1:0] rdata0_r;
    logic [WORD_WIDTH-1:0] rdata1_r;

`ifdef DMEM_ARB_RR_EN
    // 1 = port 1 was granted most recently.
    logic last_grant_r;

    // Round-robin grant: on contention the port not granted last time wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (in_req0_valid && in_req1_valid) begin
            if (last_grant_r) begin
                grant0_s = 1'b1;
                grant1_s = 1'b0;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b1;
            end
        end else begin
            grant0_s = in_req0_valid;
            grant1_s = in_req1_valid;
        end
    end

    // Remember which port was granted last. Hold when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_r <= 1'b0;
        end else if (grant1_s) begin
            last_grant_r <= 1'b1;
        end else if (grant0_s) begin
            last_grant_r <= 1'b0;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_r;
    logic [3:0] starve_cnt_s;
    logic       force1_s;

    // Port 1 has waited through STARVE_LIMIT port-0 grants, so it takes
    // this cycle.
    assign force1_s = in_req1_valid && (starve_cnt_r == STARVE_MAX);

    // Priority grant: port 0 first, unless port 1 is being forced.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (force1_s) begin
            grant0_s = 1'b0;
            grant1_s = 1'b1;
        end else if (in_req0_valid) begin
            grant0_s = 1'b1;
            grant1_s = 1'b0;
        end else begin
            grant0_s = 1'b0;
            grant1_s = in_req1_valid;
        end
    end

    // Next starve count. It counts port-0 wins while port 1 waits, and
    // saturates. Any port-1 grant or a dropped port-1 request clears it,
    // so exactly one forced grant follows each saturation.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (!in_req1_valid || grant1_s) begin
            starve_cnt_s = 4'd0;
        end else if (grant0_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_cnt_s;
        end
    end
`endif

    // Mux the granted request. Port 1 is selected only when it holds the grant.
    assign any_grant_s = grant0_s | grant1_s;
    assign sel_write_s = grant1_s ? in_req1_write : in_req0_write;
    assign sel_addr_s  = grant1_s ? in_req1_addr  : in_req0_addr;
    assign sel_wdata_s = grant1_s ? in_req1_wdata : in_req0_wdata;

    assign out_req0_ready   = grant0_s;
    assign out_req1_ready   = grant1_s;
    assign out_mem_rd_addr  = any_grant_s ? sel_addr_s  : hold_addr_r;
    assign out_mem_wr_addr  = any_grant_s ? sel_addr_s  : hold_addr_r;
    assign out_mem_wr_word  = any_grant_s ? sel_wdata_s : hold_wdata_r;
    assign out_mem_write_en = any_grant_s & sel_write_s;

    // Capture the granted address and data. They stay on the memory side while idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_addr_r  <= {ADDR_WIDTH{1'b0}};
            hold_wdata_r <= {WORD_WIDTH{1'b0}};
        end else if (any_grant_s) begin
            hold_addr_r  <= sel_addr_s;
            hold_wdata_r <= sel_wdata_s;
        end else begin
            hold_addr_r  <= hold_addr_r;
            hold_wdata_r <= hold_wdata_r;
        end
    end

    // Track the owner of an accepted read so its data goes back next cycle.
    // A new owner loads every cycle, so back-to-back reads pipeline.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_r <= 2'b00;
        end else begin
            pending_r <= {grant1_s & ~in_req1_write, grant0_s & ~in_req0_write};
        end
    end

    // Keep each port's last returned word, so a non-owner's rdata stays stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata0_r <= {WORD_WIDTH{1'b0}};
            rdata1_r <= {WORD_WIDTH{1'b0}};
        end else begin
            rdata0_r <= pending_r[0] ? in_mem_rd_word : rdata0_r;
            rdata1_r <= pending_r[1] ? in_mem_rd_word : rdata1_r;
        end
    end

    // Memory output is already registered, so the owner sees it directly.
    assign out_rsp0_valid = pending_r[0];
    assign out_rsp1_valid = pending_r[1];
    assign out_rsp0_rdata = pending_r[0] ? in_mem_rd_word : rdata0_r;
    assign out_rsp1_rdata = pending_r[1] ? in_mem_rd_word : rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter: directed, self-checking bench for dmem_arbiter in its
// default build (port-0 priority, STARVE_LIMIT = 4). A small memory model
// with a one-cycle registered read stands in for dmem_sim.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid;
    logic        req0_write;
    logic [11:0] req0_addr;
    logic [15:0] req0_wdata;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [15:0] rsp0_rdata;
    logic        req1_valid;
    logic        req1_write;
    logic [11:0] req1_addr;
    logic [15:0] req1_wdata;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [15:0] rsp1_rdata;
    logic [11:0] mem_rd_addr;
    logic [11:0] mem_wr_addr;
    logic [15:0] mem_wr_word;
    logic        mem_write_en;
    logic [15:0] mem_rd_word;

    logic [15:0] mem [0:4095];

    int n_checks;
    int n_errors;

    dmem_arbiter #(
        .ADDR_WIDTH  (12),
        .WORD_WIDTH  (16),
        .STARVE_LIMIT(4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_req0_valid   (req0_valid),
        .in_req0_write   (req0_write),
        .in_req0_addr    (req0_addr),
        .in_req0_wdata   (req0_wdata),
        .out_req0_ready  (req0_ready),
        .out_rsp0_valid  (rsp0_valid),
        .out_rsp0_rdata  (rsp0_rdata),
        .in_req1_valid   (req1_valid),
        .in_req1_write   (req1_write),
        .in_req1_addr    (req1_addr),
        .in_req1_wdata   (req1_wdata),
        .out_req1_ready  (req1_ready),
        .out_rsp1_valid  (rsp1_valid),
        .out_rsp1_rdata  (rsp1_rdata),
        .out_mem_rd_addr (mem_rd_addr),
        .out_mem_wr_addr (mem_wr_addr),
        .out_mem_wr_word (mem_wr_word),
        .out_mem_write_en(mem_write_en),
        .in_mem_rd_word  (mem_rd_word)
    );

    // Clock: period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model: registered read, write at the edge.
    always @(posedge clock) begin
        mem_rd_word <= mem[mem_rd_addr];
        if (mem_write_en) begin
            mem[mem_wr_addr] <= mem_wr_word;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic v, input logic w, input logic [11:0] a, input logic [15:0] d);
        req0_valid = v;
        req0_write = w;
        req0_addr  = a;
        req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [11:0] a, input logic [15:0] d);
        req1_valid = v;
        req1_write = w;
        req1_addr  = a;
        req1_wdata = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive0(1'b1, 1'b0, 12'h003, 16'h0000);
        drive1(1'b1, 1'b0, 12'h020, 16'h0000);
        step();
        step();
        @(negedge clock);
        n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_errors++; $display("FAIL rst_rsp_valid: got %b want 00", {rsp1_valid, rsp0_valid}); end
        n_checks++; if (mem_write_en !== 1'b0) begin n_errors++; $display("FAIL rst_write_en: got %b want 0", mem_write_en); end
        n_checks++; if (mem_rd_addr !== 12'h000) begin n_errors++; $display("FAIL rst_rd_addr: got %h want 000", mem_rd_addr); end
        n_checks++; if (rsp0_rdata !== 16'h0000) begin n_errors++; $display("FAIL rst_rdata0: got %h want 0000", rsp0_rdata); end
        step();
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_errors++; $display("FAIL post_rst_grant: got %b want 01", {req1_ready, req0_ready}); end
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_errors++; $display("FAIL post_rst_rsp: got %b want 00", {rsp1_valid, rsp0_valid}); end
        n_checks++; if (mem_rd_addr !== 12'h003) begin n_errors++; $display("FAIL post_rst_rd_addr: got %h want 003", mem_rd_addr); end
        step();
        drive0(1'b0, 1'b0, 12'h000, 16'h0000);
        drive1(1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clock);
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_errors++; $display("FAIL first_rsp: got %b want 01", {rsp1_valid, rsp0_valid}); end
        step();
    endtask

    task automatic test_write_read();
        drive0(1'b1, 1'b1, 12'h010, 16'hBEEF);
        @(negedge clock);
        n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL wr_ready0: got %b want 1", req0_ready); end
        n_checks++; if (mem_write_en !== 1'b1) begin n_errors++; $display("FAIL wr_en: got %b want 1", mem_write_en); end
        n_checks++; if (mem_wr_addr !== 12'h010) begin n_errors++; $display("FAIL wr_addr: got %h want 010", mem_wr_addr); end
        n_checks++; if (mem_wr_word !== 16'hBEEF) begin n_errors++; $display("FAIL wr_word: got %h want beef", mem_wr_word); end
        step();
        drive0(1'b1, 1'b0, 12'h010, 16'h0000);
        @(negedge clock);
        n_checks++; if (mem_write_en !== 1'b0) begin n_errors++; $display("FAIL rd_wr_en: got %b want 0", mem_write_en); end
        n_checks++; if (rsp0_valid !== 1'b0) begin n_errors++; $display("FAIL wr_no_rsp: got %b want 0", rsp0_valid); end
        n_checks++; if (mem_rd_addr !== 12'h010) begin n_errors++; $display("FAIL rd_addr: got %h want 010", mem_rd_addr); end
        step();
        drive0(1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clock);
        n_checks++; if (rsp0_valid !== 1'b1) begin n_errors++; $display("FAIL rd_rsp0_valid: got %b want 1", rsp0_valid); end
        n_checks++; if (rsp0_rdata !== 16'hBEEF) begin n_errors++; $display("FAIL rd_rsp0_data: got %h want beef", rsp0_rdata); end
        n_checks++; if (rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL rd_rsp1_quiet: got %b want 0", rsp1_valid); end
        n_checks++; if (mem_rd_addr !== 12'h010) begin n_errors++; $display("FAIL idle_addr_hold: got %h want 010", mem_rd_addr); end
        n_checks++; if (mem_write_en !== 1'b0) begin n_errors++; $display("FAIL idle_wr_en: got %b want 0", mem_write_en); end
        step();
        @(negedge clock);
        n_checks++; if (rsp0_valid !== 1'b0) begin n_errors++; $display("FAIL rsp0_single: got %b want 0", rsp0_valid); end
        n_checks++; if (rsp0_rdata !== 16'hBEEF) begin n_errors++; $display("FAIL rdata0_hold: got %h want beef", rsp0_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        drive0(1'b1, 1'b1, 12'h004, 16'hA5A5);
        step();
        drive0(1'b0, 1'b0, 12'h000, 16'h0000);
        drive1(1'b1, 1'b1, 12'h008, 16'h5A5A);
        @(negedge clock);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b10) begin n_errors++; $display("FAIL p1_wr_grant: got %b want 10", {req1_ready, req0_ready}); end
        n_checks++; if (mem_wr_addr !== 12'h008) begin n_errors++; $display("FAIL p1_wr_addr: got %h want 008", mem_wr_addr); end
        step();
        drive1(1'b0, 1'b0, 12'h000, 16'h0000);
        drive0(1'b1, 1'b0, 12'h004, 16'h0000);
        step();
        drive0(1'b0, 1'b0, 12'h000, 16'h0000);
        drive1(1'b1, 1'b0, 12'h008, 16'h0000);
        @(negedge clock);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b10) begin n_errors++; $display("FAIL b2b_grant1: got %b want 10", {req1_ready, req0_ready}); end
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_errors++; $display("FAIL b2b_rsp_a: got %b want 01", {rsp1_valid, rsp0_valid}); end
        n_checks++; if (rsp0_rdata !== 16'hA5A5) begin n_errors++; $display("FAIL b2b_data_a: got %h want a5a5", rsp0_rdata); end
        step();
        drive1(1'b0, 1'b0, 12'h000, 16'h0000);
        drive0(1'b1, 1'b0, 12'h004, 16'h0000);
        @(negedge clock);
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b10) begin n_errors++; $display("FAIL b2b_rsp_b: got %b want 10", {rsp1_valid, rsp0_valid}); end
        n_checks++; if (rsp1_rdata !== 16'h5A5A) begin n_errors++; $display("FAIL b2b_data_b: got %h want 5a5a", rsp1_rdata); end
        n_checks++; if (rsp0_rdata !== 16'hA5A5) begin n_errors++; $display("FAIL b2b_hold_a: got %h want a5a5", rsp0_rdata); end
        step();
        drive0(1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clock);
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_errors++; $display("FAIL b2b_rsp_c: got %b want 01", {rsp1_valid, rsp0_valid}); end
        n_checks++; if (rsp0_rdata !== 16'hA5A5) begin n_errors++; $display("FAIL b2b_data_c: got %h want a5a5", rsp0_rdata); end
        n_checks++; if (rsp1_rdata !== 16'h5A5A) begin n_errors++; $display("FAIL b2b_hold_b: got %h want 5a5a", rsp1_rdata); end
        step();
    endtask

    task automatic test_starvation();
        logic exp_g1;
        logic prev_g1;
        prev_g1 = 1'b0;
        drive0(1'b1, 1'b0, 12'h004, 16'h0000);
        drive1(1'b1, 1'b0, 12'h008, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            exp_g1 = ((i % 5) == 4);
            @(negedge clock);
            n_checks++; if ({req1_ready, req0_ready} !== {exp_g1, ~exp_g1}) begin n_errors++; $display("FAIL starve_grant[%0d]: got %b want %b", i, {req1_ready, req0_ready}, {exp_g1, ~exp_g1}); end
            if (i > 0) begin
                n_checks++; if ({rsp1_valid, rsp0_valid} !== {prev_g1, ~prev_g1}) begin n_errors++; $display("FAIL starve_rsp[%0d]: got %b want %b", i, {rsp1_valid, rsp0_valid}, {prev_g1, ~prev_g1}); end
                n_checks++; if ((prev_g1 ? rsp1_rdata : rsp0_rdata) !== (prev_g1 ? 16'h5A5A : 16'hA5A5)) begin n_errors++; $display("FAIL starve_data[%0d]: got %h/%h", i, rsp0_rdata, rsp1_rdata); end
            end
            prev_g1 = exp_g1;
            step();
        end
        drive0(1'b0, 1'b0, 12'h000, 16'h0000);
        drive1(1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clock);
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b10) begin n_errors++; $display("FAIL starve_last_rsp: got %b want 10", {rsp1_valid, rsp0_valid}); end
        step();
    endtask

    task automatic test_reset_mid();
        logic exp_g1;
        drive1(1'b1, 1'b0, 12'h008, 16'h0000);
        @(negedge clock);
        n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL mid_p1_accept: got %b want 1", req1_ready); end
        step();
        drive1(1'b0, 1'b0, 12'h000, 16'h0000);
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rsp1_drop: got %b want 0", rsp1_valid); end
        n_checks++; if ({rsp1_rdata, rsp0_rdata} !== 32'h0) begin n_errors++; $display("FAIL mid_rdata_clr: got %h want 0", {rsp1_rdata, rsp0_rdata}); end
        n_checks++; if (mem_rd_addr !== 12'h000) begin n_errors++; $display("FAIL mid_addr_clr: got %h want 000", mem_rd_addr); end
        step();
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_errors++; $display("FAIL mid_post_rsp_a: got %b want 00", {rsp1_valid, rsp0_valid}); end
        step();
        @(negedge clock);
        n_checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_errors++; $display("FAIL mid_post_rsp_b: got %b want 00", {rsp1_valid, rsp0_valid}); end
        // Run the starve counter up to 3, then reset. A full 0,0,0,0,1 pattern afterwards shows it cleared.
        drive0(1'b1, 1'b0, 12'h004, 16'h0000);
        drive1(1'b1, 1'b0, 12'h008, 16'h0000);
        step();
        step();
        step();
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_errors++; $display("FAIL mid_rst_ready: got %b want 00", {req1_ready, req0_ready}); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_g1 = (i == 4);
            @(negedge clock);
            n_checks++; if ({req1_ready, req0_ready} !== {exp_g1, ~exp_g1}) begin n_errors++; $display("FAIL cnt_clr_grant[%0d]: got %b want %b", i, {req1_ready, req0_ready}, {exp_g1, ~exp_g1}); end
            step();
        end
        drive0(1'b0, 1'b0, 12'h000, 16'h0000);
        drive1(1'b0, 1'b0, 12'h000, 16'h0000);
        step();
    endtask

    task automatic test_max_addr();
        drive1(1'b1, 1'b1, 12'hFFF, 16'h1234);
        @(negedge clock);
        n_checks++; if ({req1_ready, mem_write_en} !== 2'b11) begin n_errors++; $display("FAIL max_wr: got %b want 11", {req1_ready, mem_write_en}); end
        n_checks++; if (mem_wr_addr !== 12'hFFF) begin n_errors++; $display("FAIL max_wr_addr: got %h want fff", mem_wr_addr); end
        n_checks++; if (mem_wr_word !== 16'h1234) begin n_errors++; $display("FAIL max_wr_word: got %h want 1234", mem_wr_word); end
        step();
        drive1(1'b0, 1'b0, 12'h000, 16'h0000);
        drive0(1'b1, 1'b0, 12'hFFF, 16'h0000);
        @(negedge clock);
        n_checks++; if (mem_rd_addr !== 12'hFFF) begin n_errors++; $display("FAIL max_rd_addr: got %h want fff", mem_rd_addr); end
        step();
        drive0(1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clock);
        n_checks++; if (rsp0_valid !== 1'b1) begin n_errors++; $display("FAIL max_rsp_valid: got %b want 1", rsp0_valid); end
        n_checks++; if (rsp0_rdata !== 16'h1234) begin n_errors++; $display("FAIL max_rsp_data: got %h want 1234", rsp0_rdata); end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'h0000;
        end
        reset = 1'b1;
        drive0(1'b0, 1'b0, 12'h000, 16'h0000);
        drive1(1'b0, 1'b0, 12'h000, 16'h0000);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_starvation();
        test_reset_mid();
        test_max_addr();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
